pipe_hazard_ctrl: RTL and testbench

//  Sequencing controller for the ARM 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the ARM 5-stage pipeline sequencing logic.
// Holds the memory-wait FSM state encoding.
package arm_pipe_pkg;
    localparam int REG_ADDR_W      = 4;
    localparam int MEM_WAIT_CYCLES = 5;
    localparam int WCNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW / load-use hazard detection between the ID operands and the EXE/MEM destinations.
// With forwarding on, only a load sitting in EXE still forces a stall.
module hazard_detect
    import arm_pipe_pkg::*;
#(
    parameter int ADDR_W = arm_pipe_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] src1_i,
    input  logic [ADDR_W-1:0] src2_i,
    input  logic              use_src1_i,
    input  logic              use_src2_i,
    input  logic [ADDR_W-1:0] exe_dest_i,
    input  logic              exe_wb_en_i,
    input  logic              exe_mem_read_i,
    input  logic [ADDR_W-1:0] mem_dest_i,
    input  logic              mem_wb_en_i,
    input  logic              fwd_en_i,
    output logic              hazard_o
);
    logic exe_match;
    logic mem_match;

    always_comb begin
        exe_match = exe_wb_en_i && ((use_src1_i && (exe_dest_i == src1_i)) ||
                                    (use_src2_i && (exe_dest_i == src2_i)));
        mem_match = mem_wb_en_i && ((use_src1_i && (mem_dest_i == src1_i)) ||
                                    (use_src2_i && (mem_dest_i == src2_i)));
        hazard_o  = fwd_en_i ? (exe_mem_read_i && exe_match) : (exe_match || mem_match);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush sequencing: SRAM wait FSM, priority mux of freeze/branch/hazard,
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = arm_pipe_pkg::MEM_WAIT_CYCLES,
    parameter int REG_ADDR_W      = arm_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  fwd_en,
    input  logic                  exe_branch,
    input  logic                  mem_req,
    input  logic                  cnt_clr,
    output logic                  pc_freeze,
    output logic                  ifid_freeze,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_freeze,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_WAIT_CYCLES - 2);

    mem_state_e        state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              hazard;
    logic              mem_freeze;

    hazard_detect #(.ADDR_W(REG_ADDR_W)) u_hazard (
        .src1_i         (id_src1),
        .src2_i         (id_src2),
        .use_src1_i     (id_use_src1),
        .use_src2_i     (id_use_src2),
        .exe_dest_i     (exe_dest),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_read_i (exe_mem_read),
        .mem_dest_i     (mem_dest),
        .mem_wb_en_i    (mem_wb_en),
        .fwd_en_i       (fwd_en),
        .hazard_o       (hazard)
    );

    // The access is frozen from the request cycle itself; DONE releases it for one cycle.
    assign mem_freeze = ((state_q == IDLE) && mem_req) || (state_q == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (mem_req) begin
                    state_q <= WAIT;
                    wcnt_q  <= WCNT_LOAD;
                end
                WAIT: if (wcnt_q == '0) state_q <= DONE;
                      else              wcnt_q  <= wcnt_q - 1'b1;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        mem_busy    = 1'b0;
        if (!rst) begin
            mem_busy = (state_q != IDLE);
            if (mem_freeze) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                pipe_freeze = 1'b1;
            end else if (exe_branch) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (hazard) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (pc_freeze && (stall_q != '1)) stall_d = stall_q + 1'b1;
            if (ifid_flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, forwarding, SRAM freeze window,
// branch priority, mid-access reset and counter saturation/clear.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_use_src1, id_use_src2, exe_wb_en, exe_mem_read, mem_wb_en;
    logic        fwd_en, exe_branch, mem_req, cnt_clr;
    logic        pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze, mem_busy;
    logic [15:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(5), .REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_use_src2  (id_use_src2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .exe_branch   (exe_branch),
        .mem_req      (mem_req),
        .cnt_clr      (cnt_clr),
        .pc_freeze    (pc_freeze),
        .ifid_freeze  (ifid_freeze),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .pipe_freeze  (pipe_freeze),
        .mem_busy     (mem_busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze}
    function automatic logic [4:0] ctl();
        return {pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze};
    endfunction

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        id_use_src1 = 1'b0; id_use_src2 = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_wb_en = 1'b0; fwd_en = 1'b0; exe_branch = 1'b0; mem_req = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_exe_hazard();
        id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        mem_req = 1'b1;
        set_exe_hazard();
        #1;
        check("reset_ctl_forced0", {27'd0, ctl()}, 32'h0);
        check("reset_busy", {31'd0, mem_busy}, 32'h0);
        check("reset_stall", {16'd0, stall_cycles}, 32'h0);
        check("reset_flush", {16'd0, flush_events}, 32'h0);
        @(negedge clk); @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        check("idle_ctl", {27'd0, ctl()}, 32'h0);

        // Test 1: RAW against EXE, no forwarding
        @(negedge clk); set_exe_hazard(); #1;
        check("raw_exe_ctl", {27'd0, ctl()}, 32'b11010);
        // RAW against MEM via src2
        @(negedge clk); clear_inputs();
        id_src2 = 4'd5; id_use_src2 = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1; #1;
        check("raw_mem_ctl", {27'd0, ctl()}, 32'b11010);
        check("stall_after_1", {16'd0, stall_cycles}, 32'd1);
        // Source not used -> no match
        @(negedge clk); id_use_src2 = 1'b0; #1;
        check("unused_src_ctl", {27'd0, ctl()}, 32'b00000);
        check("stall_after_2", {16'd0, stall_cycles}, 32'd2);

        // Test 2: forwarding on, non-load in EXE plus MEM match -> no stall
        @(negedge clk); clear_inputs(); set_exe_hazard(); fwd_en = 1'b1;
        id_src2 = 4'd5; id_use_src2 = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1; #1;
        check("fwd_noload_ctl", {27'd0, ctl()}, 32'b00000);
        @(negedge clk); exe_mem_read = 1'b1; #1;
        check("fwd_loaduse_ctl", {27'd0, ctl()}, 32'b11010);
        check("stall_before_loaduse", {16'd0, stall_cycles}, 32'd2);
        @(negedge clk); #1;
        check("stall_after_loaduse", {16'd0, stall_cycles}, 32'd3);

        // Test 4: branch with a hazard -> flush wins
        clear_inputs(); set_exe_hazard(); exe_branch = 1'b1; #1;
        check("branch_hazard_ctl", {27'd0, ctl()}, 32'b00110);
        @(negedge clk); clear_inputs(); #1;
        check("flush_after_branch", {16'd0, flush_events}, 32'd1);
        check("stall_after_branch", {16'd0, stall_cycles}, 32'd3);

        // Test 3: SRAM access window
        @(negedge clk); mem_req = 1'b1; #1;
        check("mem_c0_ctl", {27'd0, ctl()}, 32'b11001);
        check("mem_c0_busy", {31'd0, mem_busy}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("mem_c%0d_ctl", i), {27'd0, ctl()}, 32'b11001);
            check($sformatf("mem_c%0d_busy", i), {31'd0, mem_busy}, 32'h1);
        end
        @(negedge clk); #1;
        check("mem_done_ctl", {27'd0, ctl()}, 32'b00000);
        check("mem_done_busy", {31'd0, mem_busy}, 32'h1);
        @(negedge clk); mem_req = 1'b0; #1;
        check("mem_after_busy", {31'd0, mem_busy}, 32'h0);
        check("mem_stall_cnt", {16'd0, stall_cycles}, 32'd8);

        // Test 4b: branch held during the freeze, applied in DONE
        @(negedge clk); mem_req = 1'b1; exe_branch = 1'b1; #1;
        check("br_wait_c0_ctl", {27'd0, ctl()}, 32'b11001);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("br_wait_c%0d_ctl", i), {27'd0, ctl()}, 32'b11001);
        end
        @(negedge clk); #1;
        check("br_done_ctl", {27'd0, ctl()}, 32'b00110);
        @(negedge clk); clear_inputs(); #1;
        check("br_flush_cnt", {16'd0, flush_events}, 32'd2);
        check("br_stall_cnt", {16'd0, stall_cycles}, 32'd13);

        // Test 5: reset in the third WAIT cycle
        @(negedge clk); mem_req = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        check("pre_rst_busy", {31'd0, mem_busy}, 32'h1);
        rst = 1'b1; #1;
        check("rst_mid_ctl", {27'd0, ctl()}, 32'h0);
        check("rst_mid_busy", {31'd0, mem_busy}, 32'h0);
        @(negedge clk); clear_inputs(); rst = 1'b0; #1;
        check("post_rst_busy", {31'd0, mem_busy}, 32'h0);
        check("post_rst_stall", {16'd0, stall_cycles}, 32'd0);
        check("post_rst_flush", {16'd0, flush_events}, 32'd0);
        @(negedge clk); #1;
        check("post_rst_idle_ctl", {27'd0, ctl()}, 32'h0);

        // Test 6: saturation and clear
        set_exe_hazard();
        repeat (65534) @(negedge clk);
        #1;
        check("sat_fffe", {16'd0, stall_cycles}, 32'h0000FFFE);
        repeat (3) @(negedge clk);
        #1;
        check("sat_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
        cnt_clr = 1'b1; #1;
        check("clr_pending", {16'd0, stall_cycles}, 32'h0000FFFF);
        @(negedge clk); #1;
        check("clr_stall", {16'd0, stall_cycles}, 32'h0);
        clear_inputs();
        @(negedge clk); #1;
        check("clr_flush", {16'd0, flush_events}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
